// File: rtl/key_fifo_ctrl.sv
// key_fifo_ctrl: ring-buffer controller for the keyboard character buffer.
// Keeps head/tail/count, sequences an external dual-port RAM with 1-cycle
// read latency, counts dropped pushes and serves CPU pop/status/clear.
// Ports:
//   clk_50m, BTNC           clock, async active-high reset
//   push_valid, push_data   keyboard push (one char per cycle)
//   ram_we/waddr/wdata      RAM write port (address = tail)
//   ram_raddr, ram_rdata    RAM read port (address = head, data 1 cycle later)
//   cpu_req, cpu_sel        request strobe; sel 0 pop, 1 status, 2 clear, 3 rsvd
//   cpu_ack, cpu_rdata      one-cycle response strobe and held response word
//   irq                     registered buffer-not-empty
module key_fifo_ctrl #(
    parameter int AW     = 8,
    parameter int DROP_W = 8
) (
    input  logic          clk_50m,
    input  logic          BTNC,
    input  logic          push_valid,
    input  logic [7:0]    push_data,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [7:0]    ram_wdata,
    output logic [AW-1:0] ram_raddr,
    input  logic [7:0]    ram_rdata,
    input  logic          cpu_req,
    input  logic [1:0]    cpu_sel,
    output logic          cpu_ack,
    output logic [31:0]   cpu_rdata,
    output logic          irq
);

    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(1) << AW;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        POP_RD,
        POP_CAP,
        ACK
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0]     head, tail;
    logic [CW-1:0]     count;
    logic [DROP_W-1:0] drop_cnt;
    logic [31:0]       drop_ext;
    logic [31:0]       rdata_nxt;
    logic              rdata_load;
    logic              empty, full;
    logic              clear, push_ok, pop_commit;

    assign empty      = (count == '0);
    assign full       = (count == DEPTH);
    assign clear      = (state == IDLE) && cpu_req && (cpu_sel == 2'd2);
    // A clear discards any push landing in the same cycle.
    assign push_ok    = push_valid && !full && !clear;
    assign pop_commit = (state == POP_CAP);
    assign drop_ext   = 32'(drop_cnt);

    assign ram_we    = push_ok;
    assign ram_waddr = tail;
    assign ram_wdata = push_data;
    assign ram_raddr = head;
    assign cpu_ack   = (state == ACK);

    always_comb begin
        state_nxt  = state;
        rdata_nxt  = '0;
        rdata_load = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    state_nxt  = ACK;
                    rdata_load = 1'b1;
                    case (cpu_sel)
                        2'd0: begin
                            if (!empty) begin
                                state_nxt  = POP_RD;
                                rdata_load = 1'b0;
                            end
                        end
                        2'd1: rdata_nxt = {drop_ext[7:0], 6'b0, full,
                                           empty, 16'(count)};
                        default: rdata_nxt = '0;
                    endcase
                end
            end
            POP_RD: state_nxt = POP_CAP;
            POP_CAP: begin
                state_nxt  = ACK;
                rdata_load = 1'b1;
                rdata_nxt  = {23'b0, 1'b1, ram_rdata};
            end
            ACK: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50m or posedge BTNC) begin
        if (BTNC) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_50m or posedge BTNC) begin
        if (BTNC) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            drop_cnt  <= '0;
            irq       <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            if (push_ok) begin
                tail <= tail + AW'(1);
            end
            if (clear) begin
                head <= tail;
            end else if (pop_commit) begin
                head <= head + AW'(1);
            end
            if (clear) begin
                count <= '0;
            end else begin
                count <= count + CW'(push_ok) - CW'(pop_commit);
            end
            // Full is judged on the registered count, so a push meeting a
            // pop commit while full is still dropped.
            if (clear) begin
                drop_cnt <= '0;
            end else if (push_valid && full && drop_cnt != DROP_MAX) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
            irq <= !empty;
            if (rdata_load) begin
                cpu_rdata <= rdata_nxt;
            end
        end
    end

endmodule

// File: tb/tb_key_fifo_ctrl.sv
// Self-checking bench for key_fifo_ctrl (AW = 2, depth 4) with a RAM model
// and a queue-based reference of the character buffer.
module tb_key_fifo_ctrl;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk_50m = 1'b0;
    logic          BTNC;
    logic          push_valid;
    logic [7:0]    push_data;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [7:0]    ram_wdata;
    logic [AW-1:0] ram_raddr;
    logic [7:0]    ram_rdata;
    logic          cpu_req;
    logic [1:0]    cpu_sel;
    logic          cpu_ack;
    logic [31:0]   cpu_rdata;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    int         drop_m = 0;
    int         tail_m = 0;
    logic [7:0] mem [DEPTH];

    always #10 clk_50m = ~clk_50m;

    key_fifo_ctrl #(.AW(AW), .DROP_W(8)) dut (
        .clk_50m    (clk_50m),
        .BTNC       (BTNC),
        .push_valid (push_valid),
        .push_data  (push_data),
        .ram_we     (ram_we),
        .ram_waddr  (ram_waddr),
        .ram_wdata  (ram_wdata),
        .ram_raddr  (ram_raddr),
        .ram_rdata  (ram_rdata),
        .cpu_req    (cpu_req),
        .cpu_sel    (cpu_sel),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .irq        (irq)
    );

    always @(posedge clk_50m) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    function automatic logic [AW-1:0] head_m();
        return AW'(tail_m - q.size());
    endfunction

    // One clock cycle: drive push inputs, check the write port, then
    // advance the reference model.
    task automatic step(input bit pv, input logic [7:0] pd,
                        input bit clr, input bit commit);
        bit full_m;
        bit exp_we;
        full_m = (q.size() == DEPTH);
        exp_we = pv && !full_m && !clr;
        push_valid = pv;
        push_data  = pd;
        #1;
        checks++;
        if (ram_we !== exp_we) begin
            failures++;
            $display("FAIL ram_we got=%0b exp=%0b", ram_we, exp_we);
        end
        if (exp_we) begin
            checks++;
            if (ram_waddr !== AW'(tail_m) || ram_wdata !== pd) begin
                failures++;
                $display("FAIL ram_write got=%0d/%h exp=%0d/%h",
                         ram_waddr, ram_wdata, AW'(tail_m), pd);
            end
        end
        @(posedge clk_50m);
        #1;
        push_valid = 1'b0;
        if (commit && q.size() > 0) void'(q.pop_front());
        if (clr) begin
            q.delete();
            drop_m = 0;
        end else if (pv) begin
            if (!full_m) begin
                q.push_back(pd);
                tail_m++;
            end else if (drop_m < 255) begin
                drop_m++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // mode 0: no pushes, 1: random pushes and stray requests,
    // 2: push pbyte in the POP_CAP cycle, 3: push pbyte with the request
    task automatic request(input logic [1:0] sel, input int mode,
                           input logic [7:0] pbyte, output logic [31:0] got);
        logic [31:0] exp;
        int          exp_lat;
        int          lat;
        bit          pop_data;
        bit          pv;
        logic [7:0]  pd;
        pop_data = (sel == 2'd0) && (q.size() != 0);
        exp_lat  = pop_data ? 3 : 1;
        exp      = '0;
        if (pop_data) begin
            exp = {23'b0, 1'b1, q[0]};
            checks++;
            if (ram_raddr !== head_m()) begin
                failures++;
                $display("FAIL ram_raddr got=%0d exp=%0d", ram_raddr, head_m());
            end
        end else if (sel == 2'd1) begin
            exp = {8'(drop_m), 6'b0, q.size() == DEPTH, q.size() == 0,
                   16'(q.size())};
        end
        cpu_req = 1'b1;
        cpu_sel = sel;
        pv = (mode == 1) ? 1'($urandom % 2) : (mode == 3);
        pd = (mode == 1) ? 8'($urandom) : pbyte;
        step(pv, pd, sel == 2'd2, 1'b0);
        cpu_req = 1'b0;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            if (cpu_ack === 1'b1) begin
                lat = k;
                break;
            end
            if (mode == 1 && $urandom % 3 == 0) begin
                cpu_req = 1'b1;
                cpu_sel = 2'($urandom);
            end else begin
                cpu_req = 1'b0;
            end
            pv = (mode == 1) ? 1'($urandom % 2) : (mode == 2 && k == 2);
            pd = (mode == 1) ? 8'($urandom) : pbyte;
            step(pv, pd, 1'b0, pop_data && k == 2);
        end
        got = cpu_rdata;
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL ack_latency sel=%0d got=%0d exp=%0d", sel, lat, exp_lat);
        end
        checks++;
        if (cpu_rdata !== exp) begin
            failures++;
            $display("FAIL cpu_rdata sel=%0d got=%h exp=%h", sel, cpu_rdata, exp);
        end
        cpu_req = (mode == 1) ? 1'($urandom % 2) : 1'b0;
        cpu_sel = 2'd2;
        step((mode == 1) ? 1'($urandom % 2) : 1'b0, 8'($urandom), 1'b0, 1'b0);
        cpu_req = 1'b0;
        checks++;
        if (cpu_ack !== 1'b0) begin
            failures++;
            $display("FAIL ack_one_cycle got=%0b exp=0", cpu_ack);
        end
    endtask

    task automatic test_reset();
        BTNC = 1'b1;
        repeat (3) @(posedge clk_50m);
        #1;
        checks++;
        if ({ram_we, cpu_ack, irq} !== 3'b000) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=000", {ram_we, cpu_ack, irq});
        end
        checks++;
        if (cpu_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=0", cpu_rdata);
        end
        checks++;
        if (ram_raddr !== '0 || ram_waddr !== '0) begin
            failures++;
            $display("FAIL reset_ptrs got=%0d/%0d exp=0/0", ram_raddr, ram_waddr);
        end
        BTNC = 1'b0;
        idle(1);
    endtask

    task automatic test_basic();
        logic [31:0] got;
        step(1'b1, 8'h41, 1'b0, 1'b0);
        step(1'b1, 8'h42, 1'b0, 1'b0);
        idle(1);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_nonempty got=%0b exp=1", irq);
        end
        request(2'd0, 0, 8'h00, got);
        checks++;
        if (got !== 32'h0000_0141) begin
            failures++;
            $display("FAIL pop1 got=%h exp=00000141", got);
        end
        request(2'd0, 0, 8'h00, got);
        checks++;
        if (got !== 32'h0000_0142) begin
            failures++;
            $display("FAIL pop2 got=%h exp=00000142", got);
        end
        request(2'd1, 0, 8'h00, got);
        checks++;
        if (got !== 32'h0001_0000) begin
            failures++;
            $display("FAIL status_empty got=%h exp=00010000", got);
        end
        idle(1);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_empty got=%0b exp=0", irq);
        end
    endtask

    task automatic test_empty_pop();
        logic [31:0] got;
        request(2'd0, 0, 8'h00, got);
        checks++;
        if (got !== 32'h0) begin
            failures++;
            $display("FAIL empty_pop got=%h exp=00000000", got);
        end
        request(2'd1, 0, 8'h00, got);
        checks++;
        if (got !== 32'h0001_0000) begin
            failures++;
            $display("FAIL empty_pop_status got=%h exp=00010000", got);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] got;
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        request(2'd1, 0, 8'h00, got);
        checks++;
        if (got !== 32'h0102_0004) begin
            failures++;
            $display("FAIL status_full got=%h exp=01020004", got);
        end
        for (int i = 0; i < 300; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        request(2'd1, 0, 8'h00, got);
        checks++;
        if (got !== 32'hFF02_0004) begin
            failures++;
            $display("FAIL drop_saturate got=%h exp=FF020004", got);
        end
    endtask

    task automatic test_clear();
        logic [31:0] got;
        request(2'd0, 0, 8'h00, got);
        request(2'd2, 3, 8'h55, got);
        checks++;
        if (got !== 32'h0) begin
            failures++;
            $display("FAIL clear_rdata got=%h exp=00000000", got);
        end
        request(2'd1, 0, 8'h00, got);
        checks++;
        if (got !== 32'h0001_0000) begin
            failures++;
            $display("FAIL clear_status got=%h exp=00010000", got);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] got;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
            request(2'd0, 0, 8'h00, got);
            checks++;
            if (got !== 32'h130 + 32'(i)) begin
                failures++;
                $display("FAIL wrap_pop%0d got=%h exp=%h", i, got, 32'h130 + 32'(i));
            end
        end
    endtask

    task automatic test_push_on_commit();
        logic [31:0] got;
        step(1'b1, 8'h61, 1'b0, 1'b0);
        request(2'd0, 2, 8'h62, got);
        checks++;
        if (got !== 32'h0000_0161) begin
            failures++;
            $display("FAIL commit_pop got=%h exp=00000161", got);
        end
        request(2'd1, 0, 8'h00, got);
        checks++;
        if (got !== 32'h0000_0001) begin
            failures++;
            $display("FAIL commit_count got=%h exp=00000001", got);
        end
        request(2'd0, 0, 8'h00, got);
        checks++;
        if (got !== 32'h0000_0162) begin
            failures++;
            $display("FAIL commit_next got=%h exp=00000162", got);
        end
    endtask

    task automatic test_random();
        logic [31:0] got;
        int          r;
        logic [1:0]  sel;
        for (int it = 0; it < 300; it++) begin
            r = int'($urandom % 8);
            if (r < 3) begin
                for (int j = 0; j < int'($urandom_range(1, 5)); j++)
                    step(1'($urandom % 2), 8'($urandom), 1'b0, 1'b0);
            end else begin
                sel = (r == 3) ? 2'd2 : (r < 6) ? 2'd0 : (r == 6) ? 2'd1 : 2'd3;
                request(sel, 1, 8'h00, got);
                idle(1);
                checks++;
                if (irq !== (q.size() != 0)) begin
                    failures++;
                    $display("FAIL rand_irq got=%0b exp=%0b", irq, q.size() != 0);
                end
            end
        end
    endtask

    task automatic test_reset_mid_pop();
        logic [31:0] got;
        step(1'b1, 8'h71, 1'b0, 1'b0);
        step(1'b1, 8'h72, 1'b0, 1'b0);
        cpu_req = 1'b1;
        cpu_sel = 2'd0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        cpu_req = 1'b0;
        BTNC = 1'b1;
        #1;
        checks++;
        if ({cpu_ack, irq, ram_raddr} !== '0 || cpu_rdata !== 32'h0) begin
            failures++;
            $display("FAIL async_reset got=%b/%h exp=0/0",
                     {cpu_ack, irq, ram_raddr}, cpu_rdata);
        end
        @(posedge clk_50m);
        #1;
        BTNC = 1'b0;
        q.delete();
        drop_m = 0;
        tail_m = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cpu_ack !== 1'b0) begin
                failures++;
                $display("FAIL abort_ack got=%0b exp=0", cpu_ack);
            end
            step(1'b0, 8'h00, 1'b0, 1'b0);
        end
        request(2'd1, 0, 8'h00, got);
        checks++;
        if (got !== 32'h0001_0000) begin
            failures++;
            $display("FAIL abort_status got=%h exp=00010000", got);
        end
    endtask

    initial begin
        BTNC       = 1'b1;
        push_valid = 1'b0;
        push_data  = 8'h00;
        cpu_req    = 1'b0;
        cpu_sel    = 2'd0;
        test_reset();
        test_basic();
        test_empty_pop();
        test_overflow();
        test_clear();
        test_wrap();
        test_push_on_commit();
        test_random();
        test_reset_mid_pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_fifo_ctrl.md
Name: key_fifo_ctrl

Overview:
- Ring-buffer controller for the keyboard character buffer: owns head/tail pointers, occupancy count and overflow accounting.
- Sequences the external dual-port key buffer RAM. Keyboard pushes go in on one port; CPU memory-mapped pops and status reads are served on the other.
- Sits between the keyboard scancode/ASCII path and the CPU data bus. This moves front-pointer maintenance out of software.

Parameters:
- AW, 8, RAM address width; depth = 2^AW entries (AW ≤ 15).
- DROP_W, 8, width of the saturating dropped-push counter.

Ports:
- clk_50m  in  1  system clock, all logic rising-edge.
- BTNC  in  1  asynchronous active-high reset.
- push_valid  in  1  one character push per cycle high (source pulses).
- push_data  in  8  character to enqueue.
- ram_we  out  1  write enable to RAM write port.
- ram_waddr  out  AW  write address (= tail).
- ram_wdata  out  8  write data (= push_data).
- ram_raddr  out  AW  read address (= head, combinational).
- ram_rdata  in  8  RAM read data, 1-cycle registered latency.
- cpu_req  in  1  single-cycle request strobe.
- cpu_sel  in  2  0 = pop data, 1 = read status, 2 = clear, 3 = reserved.
- cpu_ack  out  1  one-cycle response strobe.
- cpu_rdata  out  32  response word, valid while cpu_ack = 1.
- irq  out  1  buffer non-empty, registered.

Behaviour:
- Reset (async, BTNC = 1):
  - head, tail, count, drop_cnt = 0; FSM = IDLE.
  - ram_we = 0, cpu_ack = 0, cpu_rdata = 0, irq = 0.
- Flags:
  - empty = (count == 0); full = (count == 2^AW). count is AW+1 bits wide.
  - Both flags are evaluated on registered values at the start of the cycle.
- Push:
  - If push_valid and !full and not a clear cycle: ram_we = 1 combinationally, tail += 1 (wraps 2^AW−1 → 0), count += 1.
  - If push_valid and full: ram_we = 0 and the push is dropped. drop_cnt += 1, saturating at 2^DROP_W − 1.
- FSM states: IDLE, POP_RD, POP_CAP, ACK.
  - IDLE, cpu_req = 0: stay in IDLE.
  - IDLE, cpu_req with sel 0 and !empty: go to POP_RD. ram_raddr already presents head.
  - IDLE, cpu_req with sel 0 and empty: go to ACK with cpu_rdata = 0x00000000 (bit 8 = 0 means no data).
  - IDLE, cpu_req with sel 1: go to ACK with cpu_rdata = {drop_cnt[7:0], 6'b0, full, empty, count zero-extended to 16}.
  - IDLE, cpu_req with sel 2: clear takes effect this cycle. head = tail, count = 0, drop_cnt = 0; any simultaneous push is discarded. Go to ACK with cpu_rdata = 0.
  - IDLE, cpu_req with sel 3: go to ACK with cpu_rdata = 0.
  - POP_RD: wait one cycle for RAM latency, then go to POP_CAP.
  - POP_CAP: cpu_rdata ← {23'b0, 1'b1, ram_rdata}. Pop commits: head += 1 (wrap), count −= 1. Go to ACK.
  - ACK: cpu_ack = 1 for exactly one cycle, then return to IDLE. cpu_rdata holds its value until the next response.
- Latency from req to ack: status/clear/empty-pop = 1 cycle (ack on cycle N+1); data pop = 3 cycles (ack on cycle N+3).
- cpu_req seen outside IDLE is ignored. Requesters must wait for ack before issuing the next request.
- Push and pop commit in the same cycle: count unchanged, both pointers advance.
- Push arrives while full and a pop commits in that same cycle: the push is still dropped (full taken from the registered count).
- Pop in flight, i.e. count ≥ 1 at POP_RD: pushes during POP_RD/POP_CAP are accepted normally.
- irq: registered value of !empty, updated every cycle.
- Reset asserted mid-pop: FSM aborts to IDLE and no ack is issued.

Test Plan:
- Reset, then push 0x41, 0x42 (one cycle apart), then pop → first ack on N+3 with rdata 0x00000141; second pop → 0x00000142; status read → count 0, empty = 1, irq = 0.
- Pop while empty → ack on N+1 with rdata 0x00000000; head and count unchanged.
- AW = 2: push 5 chars → count 4, full = 1, drop_cnt = 1. Then push 300 more → drop_cnt saturates at 0xFF; status = 0xFF020004.
- Wrap: AW = 2, cycle 10 push/pop pairs with values 0x30..0x39 → pops return 0x30..0x39 in order; pointers wrap with no data loss.
- Push asserted in the same cycle as the POP_CAP commit, with count = 1 → count remains 1; the next pop returns the new char.
- Clear with a simultaneous push, count = 3 → count 0, drop_cnt 0, ram_we = 0 that cycle. Separately, BTNC asserted during POP_RD → no cpu_ack, all state zero.
